// File: rtl/clk_div_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// clk_div_ctrl_pkg : shared FSM encoding and default sizing for clk_div_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package clk_div_ctrl_pkg;

  localparam int unsigned c_CNT_W        = 8;
  localparam int unsigned c_DEFAULT_HALF = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/clk_div_ctrl_if.sv
// ----------------------------------------------------------------------------
// clk_div_ctrl_if : run/stop, ratio handshake and divided-clock status bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface clk_div_ctrl_if
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = c_CNT_W
);

  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             clk_div;
  logic             tick_rise;
  logic             tick_fall;
  logic             busy;
  logic [CNT_W-1:0] cur_half;

  modport master (
    output en, cfg_valid, cfg_half,
    input  cfg_ready, clk_div, tick_rise, tick_fall, busy, cur_half
  );

  modport slave (
    input  en, cfg_valid, cfg_half,
    output cfg_ready, clk_div, tick_rise, tick_fall, busy, cur_half
  );

endinterface

`default_nettype wire

// File: rtl/clk_div_ctrl_core.sv
// ----------------------------------------------------------------------------
// clk_div_ctrl_core : half-period counter, toggle flop, edge ticks, ratio load
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clk_div_ctrl_core #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DEFAULT_HALF = 9
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             count_i,
  input  wire logic             clear_i,
  input  wire logic             load_i,
  input  wire logic [CNT_W-1:0] load_val_i,
  output logic                  term_o,
  output logic                  clk_div_o,
  output logic                  tick_rise_o,
  output logic                  tick_fall_o,
  output logic [CNT_W-1:0]      cur_half_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             clk_div_q, clk_div_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             toggle;

  assign term_o = (cnt_q == half_q);

  always_comb begin
    toggle    = count_i & term_o;
    cnt_d     = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = term_o ? '0 : cnt_q + CNT_W'(1);
    end
    clk_div_d = clk_div_q ^ toggle;
    rise_d    = toggle & ~clk_div_q;
    fall_d    = toggle & clk_div_q;
    // Loads are only requested while cnt restarts at 0, so cnt never passes half
    half_d    = load_i ? load_val_i : half_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      half_q    <= CNT_W'(DEFAULT_HALF);
      clk_div_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      clk_div_q <= clk_div_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign clk_div_o   = clk_div_q;
  assign tick_rise_o = rise_q;
  assign tick_fall_o = fall_q;
  assign cur_half_o  = half_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ----------------------------------------------------------------------------
// clk_div_ctrl : run/stop FSM and ratio-update handshake around the divider core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = c_CNT_W,
  parameter int unsigned DEFAULT_HALF = c_DEFAULT_HALF
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  clk_div_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] pend_q, pend_d;

  logic             term;
  logic             clk_div_w;
  logic             count;
  logic             clear;
  logic             load;
  logic             post_div;
  logic             boundary;
  logic             xfer;

  always_comb begin
    state_d  = state_q;
    count    = 1'b0;
    clear    = 1'b0;
    // Stop decisions look at clk_div as it will be after this cycle's toggle
    post_div = clk_div_w ^ (term & (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (bus.en) state_d = RUN;
      end
      RUN: begin
        count = 1'b1;
        if (!bus.en) begin
          if (post_div) begin
            state_d = STOPPING;
          end else begin
            state_d = IDLE;
            clear   = 1'b1;
          end
        end
      end
      STOPPING: begin
        count = 1'b1;
        if (bus.en)        state_d = RUN;
        else if (!post_div) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        clear   = 1'b1;
      end
    endcase

    boundary     = count & term & clk_div_w;
    load         = pend_valid_q & ((state_q == IDLE) | boundary);
    xfer         = bus.cfg_valid & ~pend_valid_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    if (xfer) begin
      pend_valid_d = 1'b1;
      pend_d       = bus.cfg_half;
    end else if (load) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
    end
  end

  clk_div_ctrl_core #(
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) u_core (
    .clk         (clk),
    .reset_n     (reset_n),
    .count_i     (count),
    .clear_i     (clear),
    .load_i      (load),
    .load_val_i  (pend_q),
    .term_o      (term),
    .clk_div_o   (clk_div_w),
    .tick_rise_o (bus.tick_rise),
    .tick_fall_o (bus.tick_fall),
    .cur_half_o  (bus.cur_half)
  );

  assign bus.clk_div   = clk_div_w;
  assign bus.cfg_ready = ~pend_valid_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clk_div_ctrl : directed vector table plus hand-written multi-cycle sequences
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_ctrl;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  clk_div_ctrl_if #(.CNT_W(8)) bus ();

  clk_div_ctrl #(
    .CNT_W        (8),
    .DEFAULT_HALF (9)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic       en;
    logic       cv;
    logic [7:0] ch;
    logic       e_clk;
    logic       e_rise;
    logic       e_fall;
    logic       e_busy;
    logic       e_rdy;
    logic [7:0] e_half;
  } vec_t;

  vec_t vecs [16];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.tick_rise !== 1'b1 && n < 100);
    if (bus.tick_rise !== 1'b1) check("wait_rise_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.tick_fall !== 1'b1 && n < 100);
    if (bus.tick_fall !== 1'b1) check("wait_fall_timeout", 32'(n), 32'd0);
  endtask

  task automatic offer(input logic [7:0] h);
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = h;
    step();
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    // {en, cv, ch, clk_div, rise, fall, busy, ready, cur_half} after each edge
    vecs = '{
      '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9},
      '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1},
      '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1},
      '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1},
      '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1},
      '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1},
      '{1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1},
      '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1},
      '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1},
      '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0},
      '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0},
      '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0},
      '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0},
      '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0},
      '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0}
    };

    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_half  = 8'd0;

    #12;
    check("rst_clk_div", 32'(bus.clk_div), 32'd0);
    check("rst_ticks", 32'(bus.tick_rise | bus.tick_fall), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_cur_half", 32'(bus.cur_half), 32'd9);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // First rise H+1 cycles after entering RUN, then 10/10 phases
    bus.en = 1'b1;
    wait_rise(n); check("t1_first_rise", 32'(n), 32'd11);
    wait_fall(n); check("t1_high_len", 32'(n), 32'd10);
    wait_rise(n); check("t1_low_len", 32'(n), 32'd10);

    // Ratio change offered mid high phase
    offer(8'd3);
    check("t2_ready_drop", 32'(bus.cfg_ready), 32'd0);
    check("t2_half_held", 32'(bus.cur_half), 32'd9);
    wait_fall(n); check("t2_fall_at", 32'(n), 32'd9);
    check("t2_half_new", 32'(bus.cur_half), 32'd3);
    check("t2_ready_back", 32'(bus.cfg_ready), 32'd1);
    wait_rise(n); check("t2_low_len", 32'(n), 32'd4);
    wait_fall(n); check("t2_high_len", 32'(n), 32'd4);

    // Back to H=9, then stop in the high phase at cnt=4
    offer(8'd9);
    wait_rise(n); check("t3_rise_at", 32'(n), 32'd3);
    wait_fall(n); check("t3_fall_at", 32'(n), 32'd4);
    check("t3_half_9", 32'(bus.cur_half), 32'd9);
    wait_rise(n); check("t3_low_len", 32'(n), 32'd10);
    repeat (4) step();
    bus.en = 1'b0;
    step();
    check("t3_stopping_busy", 32'(bus.busy), 32'd1);
    check("t3_stopping_high", 32'(bus.clk_div), 32'd1);
    wait_fall(n); check("t3_stop_len", 32'(n), 32'd5);
    check("t3_idle_busy", 32'(bus.busy), 32'd0);
    bus.en = 1'b1;
    step();
    repeat (3) step();
    bus.en = 1'b0;
    step();
    check("t3_cut_busy", 32'(bus.busy), 32'd0);
    check("t3_cut_low", 32'(bus.clk_div), 32'd0);
    repeat (2) step();
    check("t3_cut_stays_low", 32'(bus.clk_div | bus.tick_rise), 32'd0);

    // en dropped and restored inside STOPPING leaves the phase intact
    bus.en = 1'b1;
    wait_rise(n); check("t4_first_rise", 32'(n), 32'd11);
    repeat (2) step();
    bus.en = 1'b0;
    step();
    check("t4_stopping_busy", 32'(bus.busy), 32'd1);
    bus.en = 1'b1;
    step();
    wait_fall(n); check("t4_high_rest", 32'(n), 32'd6);
    wait_rise(n); check("t4_low_len", 32'(n), 32'd10);

    // Transfer lands on the falling boundary: old H runs one more period
    repeat (9) step();
    offer(8'd0);
    check("t5_fall_now", 32'(bus.tick_fall), 32'd1);
    check("t5_half_old", 32'(bus.cur_half), 32'd9);
    check("t5_ready_low", 32'(bus.cfg_ready), 32'd0);
    wait_rise(n); check("t5_low_old", 32'(n), 32'd10);
    wait_fall(n); check("t5_high_old", 32'(n), 32'd10);
    check("t5_half_0", 32'(bus.cur_half), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t5_div2_clk%0d", i), 32'(bus.clk_div), 32'((i % 2) == 0));
      check($sformatf("t5_div2_tick%0d", i), 32'(bus.tick_rise | bus.tick_fall), 32'd1);
    end

    // Async reset in the high phase while an update is pending
    offer(8'd5);
    wait_fall(n);
    check("t6_half_5", 32'(bus.cur_half), 32'd5);
    wait_rise(n); check("t6_low_len", 32'(n), 32'd6);
    repeat (2) step();
    offer(8'd2);
    check("t6_pending", 32'(bus.cfg_ready), 32'd0);
    check("t6_high", 32'(bus.clk_div), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_clk_div", 32'(bus.clk_div), 32'd0);
    check("t6_rst_ready", 32'(bus.cfg_ready), 32'd1);
    check("t6_rst_half", 32'(bus.cur_half), 32'd9);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    bus.en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) step();
    check("t6_pending_lost", 32'(bus.cur_half), 32'd9);
    check("t6_ready_after", 32'(bus.cfg_ready), 32'd1);

    // Vector table: H=1 and H=0 operation from IDLE
    for (int i = 0; i < 16; i++) begin
      bus.en        = vecs[i].en;
      bus.cfg_valid = vecs[i].cv;
      bus.cfg_half  = vecs[i].ch;
      step();
      check($sformatf("vec%0d_clk_div", i), 32'(bus.clk_div), 32'(vecs[i].e_clk));
      check($sformatf("vec%0d_tick_rise", i), 32'(bus.tick_rise), 32'(vecs[i].e_rise));
      check($sformatf("vec%0d_tick_fall", i), 32'(bus.tick_fall), 32'(vecs[i].e_fall));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_ready", i), 32'(bus.cfg_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_cur_half", i), 32'(bus.cur_half), 32'(vecs[i].e_half));
    end
    bus.cfg_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
